// File: rtl/alu_multicycle.sv
// Registered ALU: 1-cycle ADD/SUB/CMP/SHIFT/MOV/NOP, N-iteration shift-add MUL and restoring DIV (ALU_FAST_MUL_EN makes MUL single-cycle).
// Latency 1 or N+1 cycles start->done; caller stalls on busy, new start accepted in IDLE or in the done (FIN) cycle.
module alu_multicycle #(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [2:0]     ALUControl,
  input  logic [SHW-1:0] Shamt,
  input  logic [1:0]     ShiftType,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   Result,
  output logic [3:0]     ALUFlags
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_CMP   = 3'b101;
  localparam logic [2:0] OP_MOV   = 3'b110;

`ifdef ALU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nxt;

  logic           accept, multi_op;
  logic [SHW-1:0] cnt;
  logic           run_mul;
  logic [N-1:0]   acc_hi, acc_lo, opnd;

  assign accept   = start && (state == IDLE || state == FIN);
  assign multi_op = (ALUControl == OP_DIV) || (ALUControl == OP_MUL && !FAST_MUL);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (start) state_nxt = multi_op ? RUN : FIN;
        else       state_nxt = IDLE;
      end
      RUN:     if (cnt == '0) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // ---------------- single-cycle datapath ----------------
  logic [N:0]   add_sum, sub_sum, lsl_w, lsr_w;
  logic [N-1:0] ror_w;
  logic [N-1:0] sc_val;
  logic         sc_c, sc_v, sc_wr_res, sc_wr_flg;
`ifdef ALU_FAST_MUL_EN
  logic [2*N-1:0] prod;
  assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
`endif

  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b};
    sub_sum = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    // Extra bit beside the operand catches the last bit shifted out.
    lsl_w   = {1'b0, b} << Shamt;
    if (ShiftType == 2'b10) lsr_w = $signed({b, 1'b0}) >>> Shamt;
    else                    lsr_w = {b, 1'b0} >> Shamt;
    ror_w   = (b >> Shamt) | (b << (N - int'(Shamt)));

    sc_val    = Result;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    sc_wr_res = 1'b1;
    sc_wr_flg = 1'b1;
    case (ALUControl)
      OP_ADD: begin
        sc_val = add_sum[N-1:0];
        sc_c   = add_sum[N];
        sc_v   = (a[N-1] == b[N-1]) && (add_sum[N-1] != a[N-1]);
      end
      OP_SUB, OP_CMP: begin
        sc_val    = sub_sum[N-1:0];
        sc_c      = sub_sum[N];
        sc_v      = (a[N-1] != b[N-1]) && (sub_sum[N-1] != a[N-1]);
        sc_wr_res = (ALUControl == OP_SUB);
      end
      OP_SHIFT: begin
        case (ShiftType)
          2'b00:   begin sc_val = lsl_w[N-1:0]; sc_c = lsl_w[N]; end
          2'b11:   begin sc_val = ror_w; sc_c = (Shamt != '0) && ror_w[N-1]; end
          default: begin sc_val = lsr_w[N:1]; sc_c = lsr_w[0]; end
        endcase
      end
      OP_MOV: sc_val = a;
`ifdef ALU_FAST_MUL_EN
      OP_MUL: begin
        sc_val = prod[N-1:0];
        sc_v   = |prod[2*N-1:N];
      end
`endif
      default: begin
        sc_wr_res = 1'b0;
        sc_wr_flg = 1'b0;
      end
    endcase
  end

  // ---------------- iterative MUL / DIV step ----------------
  logic [N:0]   madd, trial;
  logic [N-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, diff;
  logic [N-1:0] it_hi, it_lo, fin_res;
  logic         ge, fin_v;

  always_comb begin
    // MUL: {acc_hi, acc_lo} is the partial product, multiplier bits retire from acc_lo[0].
    madd     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(N+1){1'b0}});
    mul_hi_n = madd[N:1];
    mul_lo_n = {madd[0], acc_lo[N-1:1]};
    // DIV: acc_hi is the remainder, acc_lo shifts dividend out and quotient in.
    trial    = {acc_hi, acc_lo[N-1]};
    ge       = trial >= {1'b0, opnd};
    diff     = trial[N-1:0] - opnd;
    div_hi_n = ge ? diff : trial[N-1:0];
    div_lo_n = {acc_lo[N-2:0], ge};

    it_hi   = run_mul ? mul_hi_n : div_hi_n;
    it_lo   = run_mul ? mul_lo_n : div_lo_n;
    fin_res = it_lo;
    fin_v   = run_mul ? (|mul_hi_n) : (opnd == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      run_mul  <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      Result   <= '0;
      ALUFlags <= '0;
    end else if (accept) begin
      if (multi_op) begin
        run_mul <= (ALUControl == OP_MUL);
        cnt     <= SHW'(N - 1);
        acc_hi  <= '0;
        acc_lo  <= (ALUControl == OP_MUL) ? b : a;
        opnd    <= (ALUControl == OP_MUL) ? a : b;
      end else begin
        if (sc_wr_res) Result   <= sc_val;
        if (sc_wr_flg) ALUFlags <= {sc_val[N-1], sc_val == '0, sc_c, sc_v};
      end
    end else if (state == RUN) begin
      acc_hi <= it_hi;
      acc_lo <= it_lo;
      cnt    <= cnt - SHW'(1);
      if (cnt == '0) begin
        Result   <= fin_res;
        ALUFlags <= {fin_res[N-1], fin_res == '0, 1'b0, fin_v};
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases plus randomized ops against a plain-arithmetic reference model.
module tb_alu_multicycle;
  localparam int N = 32;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, DIV = 3'd2, MUL = 3'd3,
                         SHF = 3'd4, CMP = 3'd5, MOV = 3'd6, NOP = 3'd7;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;
`ifdef ALU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic [2:0]  ALUControl;
  logic [4:0]  Shamt;
  logic [1:0]  ShiftType;
  logic        busy, done;
  logic [31:0] Result;
  logic [3:0]  ALUFlags;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_res;
  logic [3:0]  exp_flags;

  always #5 clk = ~clk;

  alu_multicycle #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ALUControl(ALUControl), .Shamt(Shamt), .ShiftType(ShiftType),
    .busy(busy), .done(done), .Result(Result), .ALUFlags(ALUFlags)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [2:0] op);
    return (op == DIV || (op == MUL && !FAST)) ? N + 1 : 1;
  endfunction

  // Reference model: arithmetic on wide integers, shifts one bit at a time.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [4:0] sh, input logic [1:0] st,
                                 input logic [31:0] r_old, input logic [3:0] f_old,
                                 output logic [31:0] r_new, output logic [3:0] f_new);
    logic [31:0] x;
    logic [63:0] p;
    logic        c, v, wr;
    longint      s;
    x = r_old; c = 1'b0; v = 1'b0; wr = 1'b1;
    r_new = r_old; f_new = f_old;
    case (op)
      ADD: begin
        p = 64'(av) + 64'(bv); x = p[31:0]; c = p[32];
        s = longint'($signed(av)) + longint'($signed(bv)); v = (s > SMAX) || (s < SMIN);
      end
      SUB, CMP: begin
        x = av - bv; c = (av >= bv);
        s = longint'($signed(av)) - longint'($signed(bv)); v = (s > SMAX) || (s < SMIN);
        wr = (op == SUB);
      end
      MUL: begin
        p = 64'(av) * 64'(bv); x = p[31:0]; v = (p[63:32] != 0);
      end
      DIV: begin
        if (bv == 0) begin x = 32'hFFFF_FFFF; v = 1'b1; end
        else x = av / bv;
      end
      SHF: begin
        x = bv;
        for (int i = 0; i < int'(sh); i++) begin
          case (st)
            2'b00:   begin c = x[31]; x = x << 1; end
            2'b01:   begin c = x[0];  x = x >> 1; end
            2'b10:   begin c = x[0];  x = {x[31], x[31:1]}; end
            default: begin c = x[0];  x = {x[0], x[31:1]}; end
          endcase
        end
      end
      MOV: x = av;
      default: return;
    endcase
    if (wr) r_new = x;
    f_new = {x[31], x == 0, c, v};
  endfunction

  // Issues one op and waits (bounded) for done; reports latency and busy-cycle count.
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] sh, input logic [1:0] st, output int lat, output int bcnt);
    ALUControl = op; a = av; b = bv; Shamt = sh; ShiftType = st; start = 1'b1;
    tick;
    start = 1'b0;
    a = $urandom; b = $urandom; ALUControl = 3'($urandom); Shamt = 5'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      tick;
      lat++;
    end
    if (busy) bcnt++;
    ref_op(op, av, bv, sh, st, exp_res, exp_flags, exp_res, exp_flags);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; ALUControl = NOP; Shamt = '0; ShiftType = '0;
    tick; tick;
    reset = 1'b0;
    exp_res = '0; exp_flags = '0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (Result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 0", Result); end
    tests++; if (ALUFlags !== 4'h0) begin fails++; $display("FAIL reset_flags: got %h want 0", ALUFlags); end
  endtask

  task automatic test_reset_mid_div;
    int dcnt;
    ALUControl = MOV; a = 32'h1234_5678; start = 1'b1; tick; start = 1'b0; tick;
    ALUControl = DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick; start = 1'b0;
    repeat (4) tick;
    reset = 1'b1; tick; reset = 1'b0;
    exp_res = '0; exp_flags = '0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midreset_done: got %b want 0", done); end
    tests++; if (Result !== exp_res) begin fails++; $display("FAIL midreset_result: got %h want %h", Result, exp_res); end
    tests++; if (ALUFlags !== exp_flags) begin fails++; $display("FAIL midreset_flags: got %h want %h", ALUFlags, exp_flags); end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin if (done) dcnt++; tick; end
    tests++; if (dcnt != 0) begin fails++; $display("FAIL midreset_late_done: got %0d pulses want 0", dcnt); end
  endtask

  task automatic test_add_cmp;
    int lat, bc;
    run_op(ADD, 32'h7FFF_FFFF, 32'h1, '0, '0, lat, bc);
    tests++; if (lat != 1) begin fails++; $display("FAIL add_latency: got %0d want 1", lat); end
    tests++; if (Result !== 32'h8000_0000) begin fails++; $display("FAIL add_result: got %h want 80000000", Result); end
    tests++; if (ALUFlags !== 4'b1001) begin fails++; $display("FAIL add_flags: got %b want 1001", ALUFlags); end
    tick;
    run_op(CMP, 32'd5, 32'd5, '0, '0, lat, bc);
    tests++; if (Result !== 32'h8000_0000) begin fails++; $display("FAIL cmp_result_held: got %h want 80000000", Result); end
    tests++; if (ALUFlags !== 4'b0110) begin fails++; $display("FAIL cmp_flags: got %b want 0110", ALUFlags); end
    tick;
  endtask

  task automatic test_div;
    int lat, bc;
    run_op(DIV, 32'd100, 32'd7, '0, '0, lat, bc);
    tests++; if (lat != 33) begin fails++; $display("FAIL div_latency: got %0d want 33", lat); end
    tests++; if (bc != 32) begin fails++; $display("FAIL div_busy_cycles: got %0d want 32", bc); end
    tests++; if (Result !== 32'd14) begin fails++; $display("FAIL div_result: got %h want e", Result); end
    tick;
    run_op(DIV, 32'd9, 32'd0, '0, '0, lat, bc);
    tests++; if (lat != 33) begin fails++; $display("FAIL div0_latency: got %0d want 33", lat); end
    tests++; if (Result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div0_result: got %h want ffffffff", Result); end
    tests++; if (ALUFlags !== 4'b1001) begin fails++; $display("FAIL div0_flags: got %b want 1001", ALUFlags); end
    tick;
  endtask

  task automatic test_mul;
    int lat, bc;
    run_op(MUL, 32'h0001_0000, 32'h0001_0000, '0, '0, lat, bc);
    tests++; if (lat != exp_lat(MUL)) begin fails++; $display("FAIL mul_latency: got %0d want %0d", lat, exp_lat(MUL)); end
    tests++; if (bc != exp_lat(MUL) - 1) begin fails++; $display("FAIL mul_busy_cycles: got %0d want %0d", bc, exp_lat(MUL) - 1); end
    tests++; if (Result !== 32'h0) begin fails++; $display("FAIL mul_result: got %h want 0", Result); end
    tests++; if (ALUFlags !== 4'b0101) begin fails++; $display("FAIL mul_flags: got %b want 0101", ALUFlags); end
    tick;
  endtask

  task automatic test_shift;
    int lat, bc;
    run_op(SHF, '0, 32'h8000_0001, 5'd1, 2'b10, lat, bc);
    tests++; if (Result !== 32'hC000_0000) begin fails++; $display("FAIL asr_result: got %h want c0000000", Result); end
    tests++; if (ALUFlags !== 4'b1010) begin fails++; $display("FAIL asr_flags: got %b want 1010", ALUFlags); end
    tick;
    run_op(SHF, '0, 32'h8000_0001, 5'd4, 2'b11, lat, bc);
    tests++; if (Result !== 32'h1800_0000) begin fails++; $display("FAIL ror_result: got %h want 18000000", Result); end
    tests++; if (ALUFlags !== 4'b0000) begin fails++; $display("FAIL ror_flags: got %b want 0000", ALUFlags); end
    tick;
    run_op(SHF, '0, 32'h8000_0001, 5'd0, 2'b00, lat, bc);
    tests++; if (Result !== 32'h8000_0001) begin fails++; $display("FAIL lsl0_result: got %h want 80000001", Result); end
    tests++; if (ALUFlags !== 4'b1000) begin fails++; $display("FAIL lsl0_flags: got %b want 1000", ALUFlags); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] ma, mb, xa, xb;
    int lat;
    ma = $urandom; mb = $urandom; xa = $urandom; xb = $urandom;
    ALUControl = MUL; a = ma; b = mb; start = 1'b1;
    tick;
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 3 && busy) begin ALUControl = ADD; a = $urandom; b = $urandom; start = 1'b1; end
      else start = 1'b0;
      tick;
      lat++;
    end
    start = 1'b0;
    ref_op(MUL, ma, mb, '0, '0, exp_res, exp_flags, exp_res, exp_flags);
    tests++; if (lat != exp_lat(MUL)) begin fails++; $display("FAIL b2b_mul_latency: got %0d want %0d", lat, exp_lat(MUL)); end
    tests++; if (Result !== exp_res) begin fails++; $display("FAIL b2b_mul_result: got %h want %h", Result, exp_res); end
    ALUControl = ADD; a = xa; b = xb; start = 1'b1;
    tick;
    start = 1'b0;
    ref_op(ADD, xa, xb, '0, '0, exp_res, exp_flags, exp_res, exp_flags);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_add_done: got %b want 1", done); end
    tests++; if (Result !== exp_res) begin fails++; $display("FAIL b2b_add_result: got %h want %h", Result, exp_res); end
    tests++; if (ALUFlags !== exp_flags) begin fails++; $display("FAIL b2b_add_flags: got %b want %b", ALUFlags, exp_flags); end
    tick;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [2:0]  op;
    logic [31:0] av, bv;
    for (int k = 0; k < 80; k++) begin
      op = 3'($urandom_range(0, 7));
      av = $urandom;
      bv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(op, av, bv, 5'($urandom), 2'($urandom), lat, bc);
      tests++; if (lat != exp_lat(op)) begin fails++; $display("FAIL rnd_latency op=%0d: got %0d want %0d", op, lat, exp_lat(op)); end
      tests++; if (bc != exp_lat(op) - 1) begin fails++; $display("FAIL rnd_busy op=%0d: got %0d want %0d", op, bc, exp_lat(op) - 1); end
      tests++; if (Result !== exp_res) begin fails++; $display("FAIL rnd_result op=%0d a=%h b=%h: got %h want %h", op, av, bv, Result, exp_res); end
      tests++; if (ALUFlags !== exp_flags) begin fails++; $display("FAIL rnd_flags op=%0d a=%h b=%h: got %b want %b", op, av, bv, ALUFlags, exp_flags); end
      tick;
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rnd_done_pulse op=%0d: got %b want 0", op, done); end
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_div;
    test_add_cmp;
    test_div;
    test_mul;
    test_shift;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
